// File: rtl/timer_share_sched.sv
`default_nettype none
// ============================================================================
// timer_share_sched: round-robin sharing of one one-shot delay timer among
// NUM_REQ requesters, with a watchdog to recover from a missing completion.
// Revision: 1.0
// ============================================================================
module timer_share_sched #(
  parameter int NUM_REQ     = 4,
  parameter int WDOG_CYCLES = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] done,
  output logic               err,
  output logic               busy,
  output logic               tmr_start,
  input  logic               tmr_done
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WW = $clog2(WDOG_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               err_q, err_d;
  logic               tmr_start_q, tmr_start_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      win_q, win_d;
  logic [WW-1:0]      wdog_q, wdog_d;

  logic [PW:0]        cand;
  logic [PW:0]        ptr_nxt;
  logic [PW-1:0]      pick_idx;
  logic               pick_vld;

  // Rotating priority search starting at ptr, wrapping modulo NUM_REQ.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(i);
      if (cand >= (PW+1)'(NUM_REQ)) begin
        cand = cand - (PW+1)'(NUM_REQ);
      end
      if (!pick_vld && req[cand[PW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    ptr_nxt = {1'b0, win_q} + (PW+1)'(1);
    if (ptr_nxt >= (PW+1)'(NUM_REQ)) begin
      ptr_nxt = '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    done_d      = '0;
    err_d       = 1'b0;
    tmr_start_d = 1'b0;
    ptr_d       = ptr_q;
    win_d       = win_q;
    wdog_d      = wdog_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d     = ST_START;
          grant_d     = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
          win_d       = pick_idx;
          tmr_start_d = 1'b1;
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
        wdog_d  = '0;
      end
      ST_WAIT: begin
        wdog_d = wdog_q + WW'(1);
        // A real completion takes precedence over a coincident timeout.
        if (tmr_done || (wdog_q == WW'(WDOG_CYCLES - 1))) begin
          state_d = ST_DONE;
          done_d  = grant_q;
          err_d   = ~tmr_done;
          grant_d = '0;
          ptr_d   = ptr_nxt[PW-1:0];
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      done_q      <= '0;
      err_q       <= 1'b0;
      tmr_start_q <= 1'b0;
      ptr_q       <= '0;
      win_q       <= '0;
      wdog_q      <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      err_q       <= err_d;
      tmr_start_q <= tmr_start_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      wdog_q      <= wdog_d;
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign err       = err_q;
  assign tmr_start = tmr_start_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire
